i2cmb_wb_sequencer: RTL and testbench
=====================================

# i2cmb_wb_sequencer

Wishbone master that shares the iicmb I2C multi-bus controller between up to NUM_REQ requesters. Arbitrates round-robin, then turns each granted single-byte request into the full iicmb register sequence: Set Bus, Start, address byte, data write or read, Stop. Returns one status/data response per request. Sits between the requester logic and the iicmb Wishbone slave port, replacing direct register poking.

## Interface
- NUM_REQ, 2: number of requesters, 1..8.
- BUS_W, 4: width of the I2C bus-select field; selects up to 2^BUS_W busses.
- TIMEOUT, 65535: maximum number of cycles to wait for irq per iicmb command.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  one-hot grant; a request is accepted on the cycle where both valid and ready are high for that requester.
- req_bus_i  in  NUM_REQ*BUS_W  iicmb bus number, requester k in slice k.
- req_addr_i  in  NUM_REQ*7  7-bit I2C slave address.
- req_we_i  in  NUM_REQ  1 = I2C write, 0 = I2C read.
- req_wdata_i  in  NUM_REQ*8  write byte.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_id_o  out  3  index of the requester being answered.
- rsp_status_o  out  2  0 = OK, 1 = address NAK, 2 = data NAK, 3 = arbitration lost / error / timeout.
- rsp_rdata_o  out  8  read byte; 0x00 for writes and failures.
- cyc_o, stb_o, we_o  out  1 each  Wishbone master controls.
- adr_o  out  2  register select: 0 CSR, 1 DPR, 2 CMDR, 3 FSMR.
- dat_o  out  8  write data.
- dat_i  in  8  read data.
- ack_i  in  1  slave acknowledge.
- irq_i  in  1  iicmb interrupt, level.

## Operation
- Reset values: all outputs 0, RR pointer 0, state INIT.
- **WB access primitive:**
  - Drive cyc/stb/we/adr/dat together and hold them until ack_i.
  - On a read, sample dat_i in the ack cycle.
  - Drop cyc/stb the cycle after ack. Keep at least one idle cycle between accesses.
- **INIT:**
  - Write CSR = 0xC0 (enable core and interrupt), then go to ARB.
- **ARB:**
  - Scan for the first asserted req_valid_i, starting at the pointer and wrapping.
  - Assert req_ready_o for that index for exactly one cycle and latch its fields.
  - Set pointer = index+1 mod NUM_REQ.
  - If no request is valid, stay in ARB with ready = 0.
- **Command step, "CMD c":**
  - Write CMDR = c.
  - WAIT_IRQ: wait for irq_i = 1.
  - Read CMDR, which clears irq. Status bits: 7 DON, 6 NAK, 5 AL, 4 ERR.
- **Transaction sequence:**
  1. DPR = bus, then CMD 0x06 (Set Bus).
  2. CMD 0x04 (Start).
  3. DPR = {addr, ~we}, then CMD 0x01 (Write).
  4. Write path: DPR = wdata, then CMD 0x01.
  5. Read path: CMD 0x03 (Read with NAK), then read DPR to get rdata.
  6. CMD 0x05 (Stop).
  7. RESP state: pulse rsp_valid_o, then return to ARB.
- **Error rules:**
  - NAK after the address byte: status 1, skip the data step, still issue Stop.
  - NAK after the data byte: status 2, issue Stop.
  - AL or ERR on any step: status 3, no Stop, go directly to RESP.
  - Timeout:
    - Counter is cleared on every entry to WAIT_IRQ.
    - Reaching TIMEOUT gives status 3.
    - Then write CSR = 0x00 and re-enter INIT (re-enable) before RESP.
- rsp_id_o and rsp_rdata_o are stable only while rsp_valid_o is high.
- A requester deasserting valid before its grant is legal; it is simply skipped.

## Timing
- Grant: req_ready_o is high 1 cycle after entering ARB with a valid request. Fields are captured on that edge.
- Each WB access takes at least 2 cycles (assert, ack) plus 1 idle cycle; with zero-wait ack this is 3 cycles per access.
- Response: rsp_valid_o asserts exactly one cycle after the Stop's CMDR status read completes (or after the error-path read or re-init).
- Next grant: ARB earliest one cycle after rsp_valid_o.
- Reset mid-transaction:
  - Everything returns to reset values immediately; no response is issued for the aborted request.
  - The WB cycle is dropped asynchronously.
- irq_i already high on entry to WAIT_IRQ is accepted in the same cycle.

## Test plan
- **Reset/init:** release rst_ni -> first WB access is a write, adr 0, dat 0xC0; all outputs 0 before it.
- **Single write, zero-wait slave:** req0 {bus 0, addr 0x22, we 1, wdata 0xA5}, slave acks every command with DON -> WB write sequence (adr, dat) is:
  - (1, 0x00), (2, 0x06), (2, 0x04), (1, 0x44), (2, 0x01), (1, 0xA5), (2, 0x01), (2, 0x05)
  - each CMDR write followed by a CMDR read
  - response: status 0, rdata 0x00, id 0.
- **Read:** req1 {bus 1, addr 0x22, we 0}, DPR returns 0x3C -> address byte 0x45, CMD 0x03 issued, rsp {id 1, status 0, rdata 0x3C}.
- **Address NAK:** CMDR status 0xC0 after the address write -> no data step, Stop issued, status 1.
- **Round-robin:** requesters 0 and 1 continuously valid -> grants 0, 1, 0, 1; with a single valid requester it is granted every time.
- **Timeout and AL:**
  - irq withheld for TIMEOUT cycles -> CSR written 0x00 then 0xC0, status 3.
  - AL (0x20) on Start -> status 3, no CMDR 0x05 written.

Source files
------------

// File: rtl/i2cmb_wb_sequencer.sv
// Wishbone master that arbitrates NUM_REQ single-byte I2C requesters round-robin
// and expands each grant into the iicmb register sequence Set Bus/Start/Addr/Data/Stop.
module i2cmb_wb_sequencer #(
  parameter int NUM_REQ = 2,
  parameter int BUS_W   = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [NUM_REQ*BUS_W-1:0] req_bus_i,
  input  logic [NUM_REQ*7-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0]     req_we_i,
  input  logic [NUM_REQ*8-1:0]   req_wdata_i,
  output logic                   rsp_valid_o,
  output logic [2:0]             rsp_id_o,
  output logic [1:0]             rsp_status_o,
  output logic [7:0]             rsp_rdata_o,
  output logic                   cyc_o,
  output logic                   stb_o,
  output logic                   we_o,
  output logic [1:0]             adr_o,
  output logic [7:0]             dat_o,
  input  logic [7:0]             dat_i,
  input  logic                   ack_i,
  input  logic                   irq_i
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] RSP_OK       = 2'd0;
  localparam logic [1:0] RSP_ADDR_NAK = 2'd1;
  localparam logic [1:0] RSP_DATA_NAK = 2'd2;
  localparam logic [1:0] RSP_FAIL     = 2'd3;

  typedef enum logic [3:0] {
    S_INIT, S_CSR_WR, S_ARB, S_DPR_WR, S_CMD_WR, S_WAIT_IRQ,
    S_CMD_RD, S_DPR_RD, S_GAP, S_RESP
  } state_e;

  typedef enum logic [2:0] {
    ST_INIT, ST_OFF, ST_BUS, ST_START, ST_ADDR, ST_DATA, ST_READ, ST_STOP
  } step_e;

  state_e          state_q, state_d, after_q, after_d;
  step_e           step_q, step_d;
  logic [2:0]      ptr_q, ptr_d, id_q, id_d;
  logic [BUS_W-1:0] bus_q, bus_d;
  logic [6:0]      addr_q, addr_d;
  logic            we_q, we_d;
  logic [7:0]      wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]      status_q, status_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic            found;
  logic [2:0]      idx;

  function automatic logic is_access(state_e s);
    return s inside {S_CSR_WR, S_DPR_WR, S_CMD_WR, S_CMD_RD, S_DPR_RD};
  endfunction

  // Round-robin scan: first valid requester at or after the pointer, wrapping.
  always_comb begin
    int j;
    found = 1'b0;
    idx   = 3'd0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && ((req_valid_i >> j) & NUM_REQ'(1)) != '0) begin
        found = 1'b1;
        idx   = 3'(j);
      end
    end
  end

  // NOTE: async reset clears the state, so cyc/stb (decoded from state) drop immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_INIT;
      after_q  <= S_ARB;
      step_q   <= ST_INIT;
      ptr_q    <= 3'd0;
      id_q     <= 3'd0;
      bus_q    <= '0;
      addr_q   <= 7'd0;
      we_q     <= 1'b0;
      wdata_q  <= 8'd0;
      rdata_q  <= 8'd0;
      status_q <= RSP_OK;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      after_q  <= after_d;
      step_q   <= step_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      bus_q    <= bus_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      tmo_q    <= tmo_d;
    end
  end

  // NOTE: every comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_e tgt;
    logic   go;
    state_d  = state_q;
    after_d  = after_q;
    step_d   = step_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    bus_d    = bus_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    tmo_d    = '0;
    tgt      = S_ARB;
    go       = 1'b0;
    case (state_q)
      S_INIT: state_d = S_CSR_WR;
      S_CSR_WR: if (ack_i) begin
        go = 1'b1;
        if (step_q == ST_OFF) begin
          step_d = ST_INIT;
          tgt    = S_CSR_WR;
        end else begin
          // A failed status here can only come from the timeout re-init path.
          tgt = (status_q == RSP_FAIL) ? S_RESP : S_ARB;
        end
      end
      S_ARB: if (found) begin
        id_d     = idx;
        bus_d    = BUS_W'(req_bus_i >> (int'(idx) * BUS_W));
        addr_d   = 7'(req_addr_i >> (int'(idx) * 7));
        we_d     = 1'(req_we_i >> idx);
        wdata_d  = 8'(req_wdata_i >> (int'(idx) * 8));
        status_d = RSP_OK;
        rdata_d  = 8'd0;
        step_d   = ST_BUS;
        ptr_d    = (idx == 3'(NUM_REQ - 1)) ? 3'd0 : idx + 3'd1;
        state_d  = S_DPR_WR;
      end
      S_DPR_WR: if (ack_i) begin go = 1'b1; tgt = S_CMD_WR; end
      S_CMD_WR: if (ack_i) begin go = 1'b1; tgt = S_WAIT_IRQ; end
      S_WAIT_IRQ: begin
        if (irq_i) begin
          state_d = S_CMD_RD;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          status_d = RSP_FAIL;
          step_d   = ST_OFF;
          state_d  = S_CSR_WR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_CMD_RD: if (ack_i) begin
        go = 1'b1;
        if (dat_i[5] || dat_i[4]) begin
          status_d = RSP_FAIL;
          tgt      = S_RESP;
        end else begin
          case (step_q)
            ST_BUS:   begin step_d = ST_START; tgt = S_CMD_WR; end
            ST_START: begin step_d = ST_ADDR;  tgt = S_DPR_WR; end
            ST_ADDR: begin
              if (dat_i[6]) begin
                status_d = RSP_ADDR_NAK;
                step_d   = ST_STOP;
                tgt      = S_CMD_WR;
              end else if (we_q) begin
                step_d = ST_DATA;
                tgt    = S_DPR_WR;
              end else begin
                step_d = ST_READ;
                tgt    = S_CMD_WR;
              end
            end
            ST_DATA: begin
              if (dat_i[6]) status_d = RSP_DATA_NAK;
              step_d = ST_STOP;
              tgt    = S_CMD_WR;
            end
            ST_READ: tgt = S_DPR_RD;
            default: tgt = S_RESP;
          endcase
        end
      end
      S_DPR_RD: if (ack_i) begin
        go      = 1'b1;
        rdata_d = dat_i;
        step_d  = ST_STOP;
        tgt     = S_CMD_WR;
      end
      S_GAP:  state_d = after_q;
      S_RESP: state_d = S_ARB;
      default: state_d = S_INIT;
    endcase
    // Back-to-back bus accesses go through one idle cycle in S_GAP.
    if (go) begin
      after_d = tgt;
      state_d = is_access(tgt) ? S_GAP : tgt;
    end
  end

  always_comb begin
    cyc_o        = 1'b0;
    stb_o        = 1'b0;
    we_o         = 1'b0;
    adr_o        = 2'd0;
    dat_o        = 8'd0;
    req_ready_o  = '0;
    rsp_valid_o  = 1'b0;
    rsp_id_o     = 3'd0;
    rsp_status_o = 2'd0;
    rsp_rdata_o  = 8'd0;
    if (is_access(state_q)) begin
      cyc_o = 1'b1;
      stb_o = 1'b1;
    end
    case (state_q)
      S_CSR_WR: begin
        we_o  = 1'b1;
        dat_o = (step_q == ST_OFF) ? 8'h00 : 8'hC0;
      end
      S_DPR_WR: begin
        we_o  = 1'b1;
        adr_o = 2'd1;
        case (step_q)
          ST_BUS:  dat_o = 8'(bus_q);
          ST_ADDR: dat_o = {addr_q, ~we_q};
          ST_DATA: dat_o = wdata_q;
          default: dat_o = 8'h00;
        endcase
      end
      S_CMD_WR: begin
        we_o  = 1'b1;
        adr_o = 2'd2;
        case (step_q)
          ST_BUS:            dat_o = 8'h06;
          ST_START:          dat_o = 8'h04;
          ST_ADDR, ST_DATA:  dat_o = 8'h01;
          ST_READ:           dat_o = 8'h03;
          ST_STOP:           dat_o = 8'h05;
          default:           dat_o = 8'h00;
        endcase
      end
      S_CMD_RD: adr_o = 2'd2;
      S_DPR_RD: adr_o = 2'd1;
      S_ARB:    if (found) req_ready_o = NUM_REQ'(1) << idx;
      S_RESP: begin
        rsp_valid_o  = 1'b1;
        rsp_id_o     = id_q;
        rsp_status_o = status_q;
        rsp_rdata_o  = (status_q == RSP_OK) ? rdata_q : 8'h00;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// Scoreboard bench: expected WB accesses and responses are queued by the stimulus
// and popped by independent monitors; a small iicmb slave model answers the bus.
module tb_i2cmb_wb_sequencer;

  localparam int NUM_REQ = 2;
  localparam int BUS_W   = 4;
  localparam int TIMEOUT = 20;

  logic                      clk_i, rst_ni;
  logic [NUM_REQ-1:0]        req_valid_i, req_ready_o, req_we_i;
  logic [NUM_REQ*BUS_W-1:0]  req_bus_i;
  logic [NUM_REQ*7-1:0]      req_addr_i;
  logic [NUM_REQ*8-1:0]      req_wdata_i;
  logic                      rsp_valid_o;
  logic [2:0]                rsp_id_o;
  logic [1:0]                rsp_status_o;
  logic [7:0]                rsp_rdata_o;
  logic                      cyc_o, stb_o, we_o, ack_i, irq_i;
  logic [1:0]                adr_o;
  logic [7:0]                dat_o, dat_i;

  i2cmb_wb_sequencer #(.NUM_REQ(NUM_REQ), .BUS_W(BUS_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_bus_i(req_bus_i),
    .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_status_o(rsp_status_o),
    .rsp_rdata_o(rsp_rdata_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_vec = 0;
  int n_err = 0;
  logic [10:0] exp_wb[$];   // {we, adr, dat}; reads carry dat 0
  logic [12:0] exp_rsp[$];  // {id, status, rdata}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // iicmb slave model: registered ack, irq raised after each CMDR write, cleared by CMDR read.
  logic [7:0] sts_tab [8];
  logic [7:0] last_cmd;
  logic       no_irq;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_i    <= 1'b0;
      irq_i    <= 1'b0;
      last_cmd <= 8'h00;
    end else begin
      ack_i <= stb_o && !ack_i;
      if (stb_o && ack_i && adr_o == 2'd2) begin
        if (we_o) begin
          last_cmd <= dat_o;
          if (!no_irq) irq_i <= 1'b1;
        end else begin
          irq_i <= 1'b0;
        end
      end
    end
  end

  assign dat_i = (adr_o == 2'd2) ? sts_tab[last_cmd[2:0]] :
                 (adr_o == 2'd1) ? 8'h3C : 8'h00;

  // WB monitor: every acked access is popped against the expected stream.
  initial begin
    logic        prev_ack;
    logic [10:0] got;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk_i);
      if (prev_ack) check("wb_idle_after_ack", {30'd0, cyc_o, stb_o}, 32'd0);
      prev_ack = cyc_o && stb_o && ack_i;
      if (prev_ack) begin
        got = {we_o, adr_o, we_o ? dat_o : 8'h00};
        if (exp_wb.size() == 0) check("wb_unexpected", 32'(got), 32'h800);
        else                    check("wb_access", 32'(got), 32'(exp_wb.pop_front()));
      end
    end
  end

  // Response monitor.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rsp_valid_o) begin
        if (exp_rsp.size() == 0) check("rsp_unexpected", 32'd0, 32'd1);
        else check("rsp", 32'({rsp_id_o, rsp_status_o, rsp_rdata_o}), 32'(exp_rsp.pop_front()));
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    exp_wb.push_back({1'b1, a, d});
  endtask

  task automatic rd(input logic [1:0] a);
    exp_wb.push_back({1'b0, a, 8'h00});
  endtask

  // kind: 0 normal, 1 address NAK, 2 AL on Start, 3 timeout on Set Bus.
  task automatic push_txn(input logic [2:0] id, input logic [3:0] bus, input logic [6:0] addr,
                          input logic we, input logic [7:0] wd, input int kind);
    wr(2'd1, {4'h0, bus}); wr(2'd2, 8'h06);
    if (kind == 3) begin
      wr(2'd0, 8'h00); wr(2'd0, 8'hC0);
      exp_rsp.push_back({id, 2'd3, 8'h00});
      return;
    end
    rd(2'd2); wr(2'd2, 8'h04); rd(2'd2);
    if (kind == 2) begin
      exp_rsp.push_back({id, 2'd3, 8'h00});
      return;
    end
    wr(2'd1, {addr, ~we}); wr(2'd2, 8'h01); rd(2'd2);
    if (kind == 1) begin
      wr(2'd2, 8'h05); rd(2'd2);
      exp_rsp.push_back({id, 2'd1, 8'h00});
      return;
    end
    if (we) begin
      wr(2'd1, wd); wr(2'd2, 8'h01); rd(2'd2);
    end else begin
      wr(2'd2, 8'h03); rd(2'd2); rd(2'd1);
    end
    wr(2'd2, 8'h05); rd(2'd2);
    exp_rsp.push_back({id, 2'd0, we ? 8'h00 : 8'h3C});
  endtask

  task automatic set_req(input int k, input logic [3:0] bus, input logic [6:0] addr,
                         input logic we, input logic [7:0] wd);
    req_bus_i[k*BUS_W +: BUS_W] = bus;
    req_addr_i[k*7 +: 7]        = addr;
    req_we_i[k]                 = we;
    req_wdata_i[k*8 +: 8]       = wd;
  endtask

  // Wait for n accepted handshakes, returning just after the accepting edge.
  task automatic hs(input int n);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 3000) begin
      @(negedge clk_i);
      cyc++;
      if ((req_valid_i & req_ready_o) != '0) begin
        check("grant_onehot", 32'($onehot(req_ready_o)), 32'd1);
        got++;
        @(posedge clk_i);
        #1;
      end
    end
    check("grant_count", 32'(got), 32'(n));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_wb.size() != 0 || exp_rsp.size() != 0) && n < 3000) begin
      @(posedge clk_i);
      n++;
    end
    check("drain_queues", 32'(exp_wb.size() + exp_rsp.size()), 32'd0);
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  logic [10:0] t1_vec [13];

  initial begin
    rst_ni      = 1'b0;
    req_valid_i = '0;
    req_bus_i   = '0;
    req_addr_i  = '0;
    req_we_i    = '0;
    req_wdata_i = '0;
    no_irq      = 1'b0;
    for (int i = 0; i < 8; i++) sts_tab[i] = 8'h80;
    req_valid_i = 2'b11;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_outputs",
          {9'd0, cyc_o, stb_o, we_o, adr_o, dat_o, req_ready_o, rsp_valid_o,
           rsp_id_o, rsp_status_o, rsp_rdata_o[1:0]}, 32'd0);
    check("reset_rdata", 32'(rsp_rdata_o), 32'd0);
    req_valid_i = '0;

    // Init: first access is CSR = 0xC0.
    wr(2'd0, 8'hC0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drain();

    // Single write from requester 0, hand-written expected access stream.
    t1_vec = '{{1'b1, 2'd1, 8'h00}, {1'b1, 2'd2, 8'h06}, {1'b0, 2'd2, 8'h00},
               {1'b1, 2'd2, 8'h04}, {1'b0, 2'd2, 8'h00}, {1'b1, 2'd1, 8'h44},
               {1'b1, 2'd2, 8'h01}, {1'b0, 2'd2, 8'h00}, {1'b1, 2'd1, 8'hA5},
               {1'b1, 2'd2, 8'h01}, {1'b0, 2'd2, 8'h00}, {1'b1, 2'd2, 8'h05},
               {1'b0, 2'd2, 8'h00}};
    for (int i = 0; i < 13; i++) exp_wb.push_back(t1_vec[i]);
    exp_rsp.push_back({3'd0, 2'd0, 8'h00});
    set_req(0, 4'd0, 7'h22, 1'b1, 8'hA5);
    req_valid_i = 2'b01;
    hs(1);
    req_valid_i = '0;
    drain();

    // Read from requester 1: address byte 0x45, CMD 0x03, rdata 0x3C.
    push_txn(3'd1, 4'd1, 7'h22, 1'b0, 8'h00, 0);
    set_req(1, 4'd1, 7'h22, 1'b0, 8'h00);
    req_valid_i = 2'b10;
    hs(1);
    req_valid_i = '0;
    drain();

    // Round-robin with both requesters valid: 0, 1, 0, 1.
    set_req(0, 4'd2, 7'h10, 1'b1, 8'h5A);
    set_req(1, 4'd3, 7'h11, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      push_txn(3'd0, 4'd2, 7'h10, 1'b1, 8'h5A, 0);
      push_txn(3'd1, 4'd3, 7'h11, 1'b0, 8'h00, 0);
    end
    req_valid_i = 2'b11;
    hs(4);
    req_valid_i = '0;
    drain();

    // Only requester 1 valid: granted on every arbitration.
    push_txn(3'd1, 4'd3, 7'h11, 1'b0, 8'h00, 0);
    push_txn(3'd1, 4'd3, 7'h11, 1'b0, 8'h00, 0);
    req_valid_i = 2'b10;
    hs(2);
    req_valid_i = '0;
    drain();

    // Address NAK: no data step, Stop still issued, status 1.
    sts_tab[1] = 8'hC0;
    push_txn(3'd0, 4'd5, 7'h50, 1'b1, 8'h77, 1);
    set_req(0, 4'd5, 7'h50, 1'b1, 8'h77);
    req_valid_i = 2'b01;
    hs(1);
    req_valid_i = '0;
    drain();
    sts_tab[1] = 8'h80;

    // Arbitration lost on Start: status 3, no Stop.
    sts_tab[4] = 8'h20;
    push_txn(3'd1, 4'd6, 7'h33, 1'b1, 8'h12, 2);
    set_req(1, 4'd6, 7'h33, 1'b1, 8'h12);
    req_valid_i = 2'b10;
    hs(1);
    req_valid_i = '0;
    drain();
    sts_tab[4] = 8'h80;

    // irq withheld: CSR 0x00 then 0xC0, status 3.
    no_irq = 1'b1;
    push_txn(3'd0, 4'd7, 7'h0F, 1'b0, 8'h00, 3);
    set_req(0, 4'd7, 7'h0F, 1'b0, 8'h00);
    req_valid_i = 2'b01;
    hs(1);
    req_valid_i = '0;
    drain();
    no_irq = 1'b0;

    // Normal write after re-init.
    push_txn(3'd1, 4'd9, 7'h7E, 1'b1, 8'hE1, 0);
    set_req(1, 4'd9, 7'h7E, 1'b1, 8'hE1);
    req_valid_i = 2'b10;
    hs(1);
    req_valid_i = '0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk_i);
    $display("FAIL watchdog: got no finish expected finish within 60000 cycles");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
